// File: rtl/ps2_keys.sv
// ps2_keys: PS/2 keyboard receiver and scancode decoder for the game blocks.
// Synchronises the raw PS/2 pins and deframes 11-bit device-to-host frames.
// Tracks the E0 (extended) and F0 (break) prefixes.
// Drives one held-key flag per mapped key on keysout.
// Optional build macro: PS2_PARITY_CHECK_EN enables the odd-parity check.
// When the macro is undefined, the parity bit is received but ignored.

module ps2_keys #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] keysout,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_error
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam int unsigned SR_W = 10;
`else
    localparam int unsigned SR_W = 9;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      bit_cnt;
    logic [TW-1:0]   to_cnt;
    logic [SR_W-1:0] shift_reg;
    logic            ext;
    logic            brk;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall;

    logic [7:0] rx_byte;
    logic       stop_bit;
    logic       parity_ok;
    logic       shift_take;
    logic       key_hit;
    logic [1:0] key_idx;

    // Two-flop synchronisers on both pins plus a history flop for edge detection
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    assign rx_byte  = shift_reg[7:0];
    assign stop_bit = shift_reg[SR_W-1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok  = ^shift_reg[8:0];
    assign shift_take = 1'b1;
`else
    // Parity bit is skipped on its edge so the register holds only data and stop
    assign parity_ok  = 1'b1;
    assign shift_take = (bit_cnt != 4'd8);
`endif

    // Map (extended flag, byte) to a keysout bit index
    always_comb begin
        key_hit = 1'b0;
        key_idx = 2'd0;
        case ({ext, rx_byte})
            {1'b1, 8'h74}: begin key_hit = 1'b1; key_idx = 2'd0; end
            {1'b0, 8'h23}: begin key_hit = 1'b1; key_idx = 2'd0; end
            {1'b1, 8'h6B}: begin key_hit = 1'b1; key_idx = 2'd1; end
            {1'b0, 8'h1C}: begin key_hit = 1'b1; key_idx = 2'd1; end
            {1'b0, 8'h29}: begin key_hit = 1'b1; key_idx = 2'd2; end
            {1'b0, 8'h4D}: begin key_hit = 1'b1; key_idx = 2'd3; end
            default:       begin key_hit = 1'b0; key_idx = 2'd0; end
        endcase
    end

    // Frame FSM with timeout, prefix tracking and registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            to_cnt         <= '0;
            shift_reg      <= '0;
            ext            <= 1'b0;
            brk            <= 1'b0;
            keysout        <= '0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            frame_error    <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    if (fall) begin
                        if (!data_s2) begin
                            state <= SHIFT;
                        end else begin
                            frame_error <= 1'b1;
                            ext         <= 1'b0;
                            brk         <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        to_cnt <= '0;
                        if (shift_take) begin
                            shift_reg <= {data_s2, shift_reg[SR_W-1:1]};
                        end
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            state   <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        frame_error <= 1'b1;
                        ext         <= 1'b0;
                        brk         <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (stop_bit && parity_ok) begin
                        scancode       <= rx_byte;
                        scancode_valid <= 1'b1;
                        if (rx_byte == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (rx_byte == 8'hF0) begin
                            brk <= 1'b1;
                        end else begin
                            if (key_hit) begin
                                keysout[key_idx] <= ~brk;
                            end
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        ext         <= 1'b0;
                        brk         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keys.sv
// Self-checking bench for ps2_keys with a scoreboard of expected output events.
// Uses a short PS/2 bit period and a reduced timeout to keep the run short.

module tb_ps2_keys;

    localparam int unsigned HALF = 20;
    localparam int unsigned TOUT = 200;

    logic       CLOCK_50;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keysout;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_error;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] keys;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] keys_exp = 4'b0000;
    logic [7:0] last_code = 8'h00;

    ps2_keys #(.TIMEOUT_CYCLES(TOUT)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keysout        (keysout),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .frame_error    (frame_error)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Scoreboard monitor: every output pulse is matched against the queue
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (reset) begin
            if (scancode_valid || frame_error) begin
                total++;
                if (scancode_valid && frame_error) begin
                    bad++;
                    $display("FAIL both_pulses valid=%b error=%b want not both", scancode_valid, frame_error);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse valid=%b error=%b code=%h", scancode_valid, frame_error, scancode);
                end else begin
                    e = exp_q.pop_front();
                    if (frame_error !== e.is_err) begin
                        bad++;
                        $display("FAIL event_kind error=%b want %b (code want %h)", frame_error, e.is_err, e.code);
                    end
                    if (scancode !== e.code) begin
                        bad++;
                        $display("FAIL scancode got=%h want=%h", scancode, e.code);
                    end
                    if (keysout !== e.keys) begin
                        bad++;
                        $display("FAIL keysout_at_event got=%b want=%b code=%h", keysout, e.keys, e.code);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic exp_ok(input logic [7:0] code);
        exp_t e;
        e.is_err  = 1'b0;
        e.code    = code;
        e.keys    = keys_exp;
        last_code = code;
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = last_code;
        e.keys   = keys_exp;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bits(input logic [10:0] frame, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int unsigned gap);
        logic par;
        logic stp;
        par = bad_par ? ^b : ~^b;
        stp = bad_stop ? 1'b0 : 1'b1;
        ps2_bits({stp, par, b, 1'b0}, 11);
        wait_cyc(gap);
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            wait_cyc(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending left=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (keysout !== keys_exp) begin
            bad++;
            $display("FAIL %s_keys got=%b want=%b", name, keysout, keys_exp);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        total++;
        if (keysout !== 4'b0000) begin bad++; $display("FAIL reset_keys got=%b want=0000", keysout); end
        total++;
        if (scancode !== 8'h00) begin bad++; $display("FAIL reset_scancode got=%h want=00", scancode); end
        total++;
        if (scancode_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", scancode_valid); end
        total++;
        if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", frame_error); end
        reset = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_make_break();
        keys_exp = 4'b0100; exp_ok(8'h29); send_byte(8'h29, 0, 0, 2*HALF);
        exp_ok(8'hF0); send_byte(8'hF0, 0, 0, 2*HALF);
        keys_exp = 4'b0000; exp_ok(8'h29); send_byte(8'h29, 0, 0, 2*HALF);
        drain("make_break");
    endtask

    task automatic test_extended();
        exp_ok(8'hE0); send_byte(8'hE0, 0, 0, 2*HALF);
        keys_exp = 4'b0001; exp_ok(8'h74); send_byte(8'h74, 0, 0, 2*HALF);
        keys_exp = 4'b0011; exp_ok(8'h1C); send_byte(8'h1C, 0, 0, 2*HALF);
        exp_ok(8'hE0); send_byte(8'hE0, 0, 0, 2*HALF);
        exp_ok(8'hF0); send_byte(8'hF0, 0, 0, 2*HALF);
        keys_exp = 4'b0010; exp_ok(8'h74); send_byte(8'h74, 0, 0, 2*HALF);
        drain("extended");
    endtask

    task automatic test_parity();
`ifdef PS2_PARITY_CHECK_EN
        exp_err();
`else
        keys_exp = keys_exp | 4'b0100;
        exp_ok(8'h29);
`endif
        send_byte(8'h29, 1, 0, 2*HALF);
        drain("parity");
    endtask

    task automatic test_timeout();
        exp_err();
        ps2_bits({1'b1, 1'b1, 8'h23, 1'b0}, 5);
        wait_cyc(TOUT + 100);
        keys_exp = keys_exp | 4'b0001;
        exp_ok(8'h23); send_byte(8'h23, 0, 0, 2*HALF);
        drain("timeout");
    endtask

    task automatic test_stop_error();
        exp_ok(8'hF0); send_byte(8'hF0, 0, 0, 2*HALF);
        exp_err(); send_byte(8'h4D, 0, 1, 2*HALF);
        keys_exp = keys_exp | 4'b1000;
        exp_ok(8'h4D); send_byte(8'h4D, 0, 0, 2*HALF);
        drain("stop_error");
    endtask

    task automatic test_idle_glitch();
        exp_err();
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(2*HALF);
        drain("idle_glitch");
    endtask

    task automatic test_unmapped();
        exp_ok(8'h12); send_byte(8'h12, 0, 0, 2*HALF);
        exp_ok(8'h4D); send_byte(8'h4D, 0, 0, 2*HALF);
        exp_ok(8'hF0); send_byte(8'hF0, 0, 0, 2*HALF);
        exp_ok(8'h12); send_byte(8'h12, 0, 0, 2*HALF);
        keys_exp = keys_exp | 4'b0010;
        exp_ok(8'h1C); send_byte(8'h1C, 0, 0, 2*HALF);
        drain("unmapped");
    endtask

    task automatic test_reset_mid_frame();
        exp_ok(8'hE0); send_byte(8'hE0, 0, 0, 2*HALF);
        drain("pre_reset");
        ps2_bits({1'b1, 1'b0, 8'h74, 1'b0}, 4);
        reset = 1'b0;
        wait_cyc(3);
        total++;
        if (keysout !== 4'b0000) begin bad++; $display("FAIL midreset_keys got=%b want=0000", keysout); end
        total++;
        if (scancode !== 8'h00) begin bad++; $display("FAIL midreset_scancode got=%h want=00", scancode); end
        reset = 1'b1;
        keys_exp  = 4'b0000;
        last_code = 8'h00;
        wait_cyc(10);
        exp_ok(8'h74); send_byte(8'h74, 0, 0, 2*HALF);
        drain("reset_mid_frame");
    endtask

    task automatic test_back_to_back();
        keys_exp = 4'b0010; exp_ok(8'h1C); send_byte(8'h1C, 0, 0, 0);
        keys_exp = 4'b0011; exp_ok(8'h23); send_byte(8'h23, 0, 0, 0);
        exp_ok(8'hF0); send_byte(8'hF0, 0, 0, 0);
        keys_exp = 4'b0001; exp_ok(8'h1C); send_byte(8'h1C, 0, 0, 2*HALF);
        drain("back_to_back");
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_parity();
        test_timeout();
        test_stop_error();
        test_idle_glitch();
        test_unmapped();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
